bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Parametrised, multi-cycle binary-to-BCD converter using the shift/add-3 (double-dabble) method.
//  Runs one bit per clock, which suits wide counts that would need a large combinational add-3 array.
//  Sits between the occupancy counter and the 7-segment display driver.
//  Uses a valid/ready handshake on both sides, flags values too large for DIGITS, and reports the
//  significant-digit count for leading-zero blanking.
// PARAMETERS
//  BIN_W   8  width of the binary input (>=1)
//  DIGITS  3  number of BCD output digits (>=1); overflow is flagged when the input exceeds 10^DIGITS-1
// PORTS
//  clk       in   1                    single clock; all state updates on the rising edge
//  rst_n     in   1                    reset, asynchronous assert, active-low
//  in_valid  in   1                    in_bin is valid
//  in_ready  out  1                    converter idle and able to accept
//  in_bin    in   BIN_W                unsigned binary value
//  out_valid out  1                    result fields are valid and held
//  out_ready in   1                    downstream consumes the result
//  out_bcd   out  4*DIGITS             packed BCD; digit 0 is in [3:0] (ones)
//  out_ndig  out  $clog2(DIGITS+1)     significant digits, 1..DIGITS (value 0 gives 1)
//  out_ovf   out  1                    input > 10^DIGITS-1; out_bcd is saturated to all 9s
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE; out_valid=0, out_bcd=0, out_ndig=0, out_ovf=0;
//   internal shift register and counter are cleared.
//  in_ready = (state==IDLE). It reads 1 during reset and stays 1 afterwards.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   IDLE:  on an edge with in_valid&&in_ready, capture in_bin into the shift register, clear the
//          BCD accumulator and the sticky ovf, set cnt=BIN_W, go to SHIFT.
//   SHIFT: each edge, first add 3 to every accumulator digit >=5, then shift {acc,bin} left by 1.
//          The bit shifted out of the top digit sets sticky ovf. Decrement cnt.
//          When cnt reaches 0 (i.e. after BIN_W SHIFT edges), register the results and go to DONE.
//   DONE:  out_valid=1. out_bcd, out_ndig and out_ovf are held stable while out_ready=0.
//          On an edge with out_valid&&out_ready, clear out_valid and go to IDLE.
//  Latency: with accept at edge E0, out_valid rises after edge E_BIN_W.
//   Minimum period between accepts is BIN_W+2 cycles (no same-cycle DONE->accept bypass).
//  Input handshake: in_valid while busy is ignored (not queued). in_bin is sampled only at the
//   accept edge; later changes have no effect on the conversion.
//  Overflow: ovf is sticky within a conversion. If ovf, out_bcd={DIGITS{4'h9}} and out_ndig=DIGITS.
//  out_ndig: index of the highest nonzero digit plus 1; returns 1 when all digits are 0.
//  Width rules: cnt is $clog2(BIN_W+1) bits. All arithmetic is unsigned. Add-3 is per nibble with no
//   carry between digits.
//  Reset mid-operation: the conversion is aborted immediately; no partial result is ever presented.
//  out_bcd, out_ndig and out_ovf are registered and change only at the DONE transition or on reset.
//   They keep their last value in IDLE and SHIFT but are qualified only by out_valid.
// TESTING
//  1 BIN_W=8, DIGITS=3: in_bin=255 accepted at E0 -> out_valid after E8, out_bcd=12'h255, ndig=3,
//    ovf=0.
//  2 in_bin=0 -> out_bcd=12'h000, ndig=1, ovf=0; in_bin=7 -> 12'h007, ndig=1;
//    in_bin=10 -> 12'h010, ndig=2.
//  3 DIGITS=2: in_bin=99 -> 8'h99, ovf=0, ndig=2; in_bin=100 -> 8'h99, ovf=1;
//    in_bin=255 -> 8'h99, ovf=1.
//  4 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, and
//    in_bin=42 with in_valid=1 is not accepted. Set out_ready=1 -> in_ready=1 the next cycle.
//  5 Reset during SHIFT (3rd shift edge) -> out_valid=0, out_bcd=0, in_ready=1. Then in_bin=137 ->
//    out_bcd=12'h137 after 8 cycles.
//  6 Exhaustive sweep 0..255 back-to-back with out_ready=1 vs a reference model.
//    BIN_W=16, DIGITS=5: 65535 -> 20'h65535; 40000 -> 20'h40000, ndig=5.

Source files
------------

// File: rtl/bin2bcd_if.sv
// Handshake bundle for the sequential binary-to-BCD converter: input valid/ready plus held result.
interface bin2bcd_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [NDIG_W-1:0]     out_ndig;
    logic                  out_ovf;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ndig, out_ovf
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ndig, out_ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// One-bit-per-clock double-dabble converter with overflow saturation and significant-digit count.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    bin2bcd_if.slave  bus
);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e              state_q, state_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [BCD_W-1:0]    out_bcd_q, out_bcd_d;
    logic [NDIG_W-1:0]   out_ndig_q, out_ndig_d;
    logic                out_ovf_q, out_ovf_d;

    logic [BCD_W-1:0]    adj_c;
    logic [BCD_W-1:0]    sh_acc_c;
    logic                sh_ovf_c;
    logic [NDIG_W-1:0]   ndig_c;

    // Per-digit add-3 correction, then the one-bit shift of {acc,bin}; no carry between digits.
    always_comb begin
        adj_c = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        sh_acc_c = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
        sh_ovf_c = ovf_q | adj_c[BCD_W-1];
        ndig_c   = NDIG_W'(1);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sh_acc_c[4*i +: 4] != 4'd0) begin
                ndig_c = NDIG_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_ndig_d  = out_ndig_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bin_d      = bus.in_bin;
                    acc_d      = '0;
                    ovf_d      = 1'b0;
                    cnt_d      = CNT_W'(BIN_W);
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = sh_acc_c;
                bin_d = bin_q << 1;
                ovf_d = sh_ovf_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_valid_d = 1'b1;
                    out_ovf_d   = sh_ovf_c;
                    out_bcd_d   = sh_ovf_c ? {DIGITS{4'h9}} : sh_acc_c;
                    out_ndig_d  = sh_ovf_c ? NDIG_W'(DIGITS) : ndig_c;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // in_ready is held high through reset so the converter reads idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_ndig_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_ndig_q  <= out_ndig_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_ndig  = out_ndig_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
